// File: rtl/quiz_vector_sequencer.sv
// Sweeps {x,y,z} through 0..7, holding each vector DWELL cycles, and captures f_in into an 8-entry table.
// Latency: capture visible one cycle after the last dwell cycle; rd_data one cycle after rd_addr; start ignored while busy.
module quiz_vector_sequencer #(
  parameter int DWELL = 100,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic [5:0] f_in,
  output logic       busy,
  output logic       done,
  output logic       sample_valid,
  output logic [2:0] sample_idx,
  output logic [5:0] sample_data,
  input  logic [2:0] rd_addr,
  output logic [5:0] rd_data
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [5:0]       tbl [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      {x, y, z}    <= 3'b000;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_data  <= '0;
      rd_data      <= '0;
      for (int i = 0; i < 8; i++) tbl[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      // Read sees the pre-edge contents, so a same-edge write returns the old entry.
      rd_data      <= tbl[rd_addr];
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            {x, y, z} <= 3'b000;
          end
        end
        DRIVE: begin
          if (cnt == LAST) begin
            tbl[idx]     <= f_in;
            sample_valid <= 1'b1;
            sample_idx   <= idx;
            sample_data  <= f_in;
            cnt          <= '0;
            if (idx == 3'd7) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx       <= idx + 3'd1;
              {x, y, z} <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_vector_sequencer.sv
// Randomised scoreboard bench for quiz_vector_sequencer at DWELL=4 and DWELL=1.
module tb_quiz_vector_sequencer;

  typedef struct {
    logic [2:0] idx;
    logic [5:0] dat;
  } smp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0, start1 = 1'b0;
  logic       x4, y4, z4, x1, y1, z1;
  logic [5:0] f4, f1, mask4 = '0, mask1 = '0;
  logic       busy4, done4, sv4, busy1, done1, sv1;
  logic [2:0] si4, si1, ra4 = '0, ra1 = '0;
  logic [5:0] sd4, sd1, rd4, rd1;

  int   n_cmp = 0;
  int   n_bad = 0;
  smp_t q4[$];
  smp_t q1[$];
  logic [5:0] exp_tab4 [8];

  always #5 clk = ~clk;

  // Device under test modelled as combinational {x,y,z,~x,~y,~z}, optionally scrambled by a mask.
  assign f4 = {x4, y4, z4, ~x4, ~y4, ~z4} ^ mask4;
  assign f1 = {x1, y1, z1, ~x1, ~y1, ~z1} ^ mask1;

  quiz_vector_sequencer #(.DWELL(4), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4), .z(z4), .f_in(f4),
    .busy(busy4), .done(done4), .sample_valid(sv4), .sample_idx(si4),
    .sample_data(sd4), .rd_addr(ra4), .rd_data(rd4));

  quiz_vector_sequencer #(.DWELL(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .z(z1), .f_in(f1),
    .busy(busy1), .done(done1), .sample_valid(sv1), .sample_idx(si1),
    .sample_data(sd1), .rd_addr(ra1), .rd_data(rd1));

  function automatic logic [5:0] model(input int i, input logic [5:0] m);
    logic [2:0] v;
    v = 3'(i);
    return {v, ~v} ^ m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep4();
    for (int i = 0; i < 8; i++) begin
      smp_t s;
      s.idx = 3'(i);
      s.dat = model(i, mask4);
      q4.push_back(s);
    end
  endtask

  // Monitors: pop the expected capture whenever a strobe appears.
  always begin
    @(posedge clk);
    #1;
    if (sv4) begin
      if (q4.size() == 0) chk("u4_unexpected_sample", 1, 0);
      else begin
        smp_t s;
        s = q4.pop_front();
        chk("u4_sample_idx", si4, s.idx);
        chk("u4_sample_data", sd4, s.dat);
      end
    end
    if (sv1) begin
      if (q1.size() == 0) chk("u1_unexpected_sample", 1, 0);
      else begin
        smp_t s;
        s = q1.pop_front();
        chk("u1_sample_idx", si1, s.idx);
        chk("u1_sample_data", sd1, s.dat);
      end
    end
  end

  // Full DWELL=4 sweep starting from IDLE/DONE; optional start re-pulse at cycle rep.
  task automatic sweep4(input int rep);
    start4 = 1'b1;
    push_sweep4();
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      chk("u4_busy", busy4, 1);
      chk("u4_vector", {x4, y4, z4}, c / 4);
      if (c == 0) chk("u4_done_cleared", done4, 0);
      start4 = (c == rep);
      tick();
    end
    start4 = 1'b0;
    chk("u4_done", done4, 1);
    chk("u4_busy_end", busy4, 0);
    tick();
    chk("u4_samples_left", q4.size(), 0);
    for (int i = 0; i < 8; i++) exp_tab4[i] = model(i, mask4);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_tab4[i] = '0;
    // Test 1: reset state and empty table.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_outputs", {x4, y4, z4, busy4, done4, sv4, si4, sd4}, 0);
    for (int a = 0; a < 8; a++) begin
      ra4 = 3'(a);
      tick();
      chk("rst_rd_data", rd4, 0);
    end

    // Test 2: nominal sweep with the plain model.
    repeat ($urandom_range(1, 5)) tick();
    sweep4(-1);

    // Test 3: random-order readback, vector parked at 111.
    for (int k = 0; k < 12; k++) begin
      int a;
      a = $urandom_range(0, 7);
      ra4 = 3'(a);
      tick();
      chk("rd_data", rd4, exp_tab4[a]);
      chk("parked_vector", {x4, y4, z4}, 7);
    end

    // Test 4: restart from DONE with a re-pulse mid-sweep and a new data mask.
    for (int r = 0; r < 2; r++) begin
      mask4 = 6'($urandom);
      sweep4(r == 0 ? 10 : $urandom_range(1, 30));
    end
    ra4 = 3'($urandom_range(0, 7));
    tick();
    chk("rd_after_restart", rd4, exp_tab4[ra4]);

    // Test 5: reset during vector 5 aborts and clears the table.
    start4 = 1'b1;
    push_sweep4();
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 22; c++) tick();
    chk("u4_vector5", {x4, y4, z4}, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outputs", {x4, y4, z4, busy4, done4}, 0);
    chk("abort_pending", q4.size(), 3);
    q4.delete();
    for (int a = 0; a < 8; a++) begin
      ra4 = 3'(a);
      tick();
      chk("abort_rd_data", rd4, 0);
    end

    // Test 6: DWELL=1 gives eight back-to-back captures.
    mask1 = 6'($urandom);
    start1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      smp_t s;
      s.idx = 3'(i);
      s.dat = model(i, mask1);
      q1.push_back(s);
    end
    tick();
    start1 = 1'b0;
    chk("u1_first_cycle_sv", sv1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("u1_sv_run", sv1, 1);
      chk("u1_done_timing", done1, i == 7);
    end
    tick();
    chk("u1_sv_end", sv1, 0);
    chk("u1_samples_left", q1.size(), 0);
    ra1 = 3'd3;
    tick();
    chk("u1_rd_data", rd1, model(3, mask1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
